// File: rtl/bus_slave_responder.sv
// Bit-serial bus slave: deserialises address/write data into a local byte memory
// and serialises read data back after a fixed wait-state latency.
module bus_slave_responder #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_ADDR_BITS = 11,
  parameter int READ_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mvalid,
  input  logic                  mmode,
  input  logic                  mwdata,
  output logic                  sready,
  output logic                  svalid,
  output logic                  srdata,
  output logic [DATA_WIDTH-1:0] last_wdata
);

  localparam int CNT_W = $clog2(ADDR_WIDTH + DATA_WIDTH + 16);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RLAT  = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                   state;
  logic                     mode;
  logic [CNT_W-1:0]         cnt;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic [DATA_WIDTH-2:0]    wdata_sr;
  logic [DATA_WIDTH-1:0]    rdata_sr;
  logic [DATA_WIDTH-1:0]    mem [2**MEM_ADDR_BITS];
  logic [DATA_WIDTH-1:0]    wword;
  logic [DATA_WIDTH-1:0]    rword;
  logic                     commit;

  // Address bits at or above MEM_ADDR_BITS shift out of range and vanish, giving the alias wrap.
  assign wword  = {mwdata, wdata_sr};
  assign rword  = mem[mem_idx];
  assign commit = !rst && (state == WDATA) && mvalid && (cnt == DATA_LAST);
  assign sready = (state == IDLE);

  // Local storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[mem_idx] <= wword;
    end
  end

  // Transaction sequencer with registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      cnt        <= '0;
      mem_idx    <= '0;
      wdata_sr   <= '0;
      rdata_sr   <= '0;
      svalid     <= 1'b0;
      srdata     <= 1'b0;
      last_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mvalid) begin
            mode    <= mmode;
            mem_idx <= MEM_ADDR_BITS'(mwdata);
            cnt     <= CNT_ONE;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (!mvalid) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            mem_idx <= mem_idx | (MEM_ADDR_BITS'(mwdata) << cnt);
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= mode ? WDATA : RLAT;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        WDATA: begin
          if (!mvalid) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            wdata_sr <= wword[DATA_WIDTH-1:1];
            if (cnt == DATA_LAST) begin
              last_wdata <= wword;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        RLAT: begin
          // Bit 0 goes straight to srdata; the shift register keeps the remainder.
          rdata_sr <= {1'b0, rword[DATA_WIDTH-1:1]};
          if (cnt == LAT_LAST) begin
            srdata <= rword[0];
            svalid <= 1'b1;
            cnt    <= '0;
            state  <= RDATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RDATA: begin
          if (cnt == DATA_LAST) begin
            svalid <= 1'b0;
            srdata <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            srdata   <= rdata_sr[0];
            rdata_sr <= {1'b0, rdata_sr[DATA_WIDTH-1:1]};
            cnt      <= cnt + CNT_ONE;
          end
        end
        default: begin
          svalid <= 1'b0;
          srdata <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
